parser_grp_sched: RTL and testbench

- Scheduler in front of sub0_parser.
- Owns the ping-pong segment-RAM bank bookkeeping: which bank the segment writer fills and which bank the extractor reads.
- Accepts a full per-packet parser instruction vector, then issues it to sub0_parser one 32-bit group (two 16-bit actions) at a time, paced to sub0_parser's 4-cycle group service time.
- Releases the bank after the last group, so writer and extractor never collide on the same bank.

---
 rtl/parser_grp_sched_pkg.sv | 27 ++
 rtl/parser_grp_sched_if.sv | 29 ++
 rtl/parser_grp_sched_bank_tracker.sv | 67 ++++++
 rtl/parser_grp_sched.sv | 123 ++++++++++++
 tb/tb_parser_grp_sched.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/parser_grp_sched_pkg.sv
// Shared constants, state encoding and group-enable helper for the parser group scheduler.
package parser_grp_sched_pkg;

  localparam int PARSER_WIDTH       = 16;
  localparam int DO_PARER_GROUP_NUM = 2;
  localparam int GROUP_W            = DO_PARER_GROUP_NUM * PARSER_WIDTH;
  localparam int N_GROUPS           = 12;
  localparam int GROUP_GAP          = 4;
  localparam int IDX_W              = 4;
  localparam int GAP_CNT_W          = (GROUP_GAP > 1) ? $clog2(GROUP_GAP) : 1;

  // Bit 7 of each action's high byte marks that action as enabled.
  localparam int EN_BIT_LO = 15;
  localparam int EN_BIT_HI = 31;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_GAP     = 2'd2,
    ST_RELEASE = 2'd3
  } sched_state_e;

  function automatic logic group_live(input logic [GROUP_W-1:0] grp);
    return grp[EN_BIT_HI] | grp[EN_BIT_LO];
  endfunction

endpackage

// File: rtl/parser_grp_sched_if.sv
// Instruction, segment-writer and sub0_parser signals of the group scheduler.
interface parser_grp_sched_if;
  import parser_grp_sched_pkg::*;

  logic [N_GROUPS*GROUP_W-1:0] i_inst_vec;
  logic                        i_inst_valid;
  logic                        o_inst_ready;
  logic                        i_seg_end;
  logic                        o_seg_ready;
  logic                        o_wr_bank;
  logic                        o_rd_bank;
  logic [GROUP_W-1:0]          o_parser_bram;
  logic                        o_parser_bram_valid;
  logic                        o_done;
  logic                        o_overrun;

  modport slave (
    input  i_inst_vec, i_inst_valid, i_seg_end,
    output o_inst_ready, o_seg_ready, o_wr_bank, o_rd_bank,
           o_parser_bram, o_parser_bram_valid, o_done, o_overrun
  );

  modport master (
    output i_inst_vec, i_inst_valid, i_seg_end,
    input  o_inst_ready, o_seg_ready, o_wr_bank, o_rd_bank,
           o_parser_bram, o_parser_bram_valid, o_done, o_overrun
  );

endinterface

// File: rtl/parser_grp_sched_bank_tracker.sv
// Ping-pong segment-RAM bookkeeping: which bank is full, which one the writer
// fills next and which one the extractor reads.
module pp_bank_tracker (
  input  logic clk,
  input  logic rst,
  input  logic seg_end,
  input  logic release_bank,
  output logic seg_ready,
  output logic wr_bank,
  output logic rd_bank,
  output logic rd_full,
  output logic overrun
);

  logic [1:0] bank_full_q, bank_full_d;
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic       overrun_q, overrun_d;
  logic       en_q, en_d;
  logic       seg_accept;

  // en_q keeps seg_ready low until the first clock after reset is released.
  assign seg_ready  = en_q & ~bank_full_q[wr_bank_q];
  assign seg_accept = seg_end & seg_ready;
  assign wr_bank    = wr_bank_q;
  assign rd_bank    = rd_bank_q;
  assign rd_full    = bank_full_q[rd_bank_q];
  assign overrun    = overrun_q;

  // Release and fill can land together; they never target the same bank.
  always_comb begin
    bank_full_d = bank_full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    overrun_d   = overrun_q;
    en_d        = 1'b1;
    if (release_bank) begin
      bank_full_d[rd_bank_q] = 1'b0;
      rd_bank_d              = ~rd_bank_q;
    end
    if (seg_accept) begin
      bank_full_d[wr_bank_q] = 1'b1;
      wr_bank_d              = ~wr_bank_q;
    end
    if (seg_end && !seg_ready) begin
      overrun_d = 1'b1;
    end
  end

  // Bank state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_full_q <= 2'b00;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      overrun_q   <= 1'b0;
      en_q        <= 1'b0;
    end else begin
      bank_full_q <= bank_full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      overrun_q   <= overrun_d;
      en_q        <= en_d;
    end
  end

endmodule

// File: rtl/parser_grp_sched.sv
// Accepts a parser instruction vector for the full read bank and feeds it to
// sub0_parser one group at a time, skipping disabled groups.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a vector while the read bank is full
// ST_ISSUE   | strobe the current group if live, else skip it in one cycle
// ST_GAP     | pacing to sub0_parser's group service time
// ST_RELEASE | free the read bank and flip to the other one
module parser_grp_sched
  import parser_grp_sched_pkg::*;
(
  input  logic              axis_clk,
  input  logic              areset,
  parser_grp_sched_if.slave bus
);

  sched_state_e                      state_q, state_d;
  logic [N_GROUPS-1:0][GROUP_W-1:0]  vec_q, vec_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;
  logic [GAP_CNT_W-1:0]              cnt_q, cnt_d;
  logic [GROUP_W-1:0]                bram_q, bram_d;
  logic                              done_q, done_d;

  logic [GROUP_W-1:0] cur_group;
  logic               cur_live;
  logic               last_group;
  logic               hs;
  logic               issue_strobe;
  logic               release_bank;
  logic               rd_full;

  pp_bank_tracker u_bank (
    .clk          (axis_clk),
    .rst          (areset),
    .seg_end      (bus.i_seg_end),
    .release_bank (release_bank),
    .seg_ready    (bus.o_seg_ready),
    .wr_bank      (bus.o_wr_bank),
    .rd_bank      (bus.o_rd_bank),
    .rd_full      (rd_full),
    .overrun      (bus.o_overrun)
  );

  assign cur_group  = vec_q[idx_q];
  assign cur_live   = group_live(cur_group);
  assign last_group = (idx_q == IDX_W'(N_GROUPS - 1));
  assign hs         = bus.o_inst_ready & bus.i_inst_valid;

  assign bus.o_inst_ready        = (state_q == ST_IDLE) & rd_full;
  assign bus.o_parser_bram       = bram_d;
  assign bus.o_parser_bram_valid = issue_strobe;
  assign bus.o_done              = done_q;

  // State and datapath registers; reset aborts any vector in flight.
  always_ff @(posedge axis_clk or posedge areset) begin
    if (areset) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      bram_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      bram_q  <= bram_d;
      done_q  <= done_d;
    end
  end

  // Next state: walk the groups, pausing GROUP_GAP cycles after each strobe.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          vec_d   = bus.i_inst_vec;
          idx_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cur_live && (GROUP_GAP > 1)) begin
          cnt_d   = GAP_CNT_W'(GROUP_GAP - 1);
          state_d = ST_GAP;
        end else if (last_group) begin
          state_d = ST_RELEASE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_GAP: begin
        cnt_d = cnt_q - GAP_CNT_W'(1);
        if (cnt_q == GAP_CNT_W'(1)) begin
          if (last_group) begin
            state_d = ST_RELEASE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_ISSUE;
          end
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs: strobe is combinational so the first group leaves one cycle after
  // the handshake; the group bus holds its last value between strobes.
  always_comb begin
    issue_strobe = (state_q == ST_ISSUE) & cur_live;
    release_bank = (state_q == ST_RELEASE);
    bram_d       = issue_strobe ? cur_group : bram_q;
    done_d       = release_bank;
  end

endmodule

// File: tb/tb_parser_grp_sched.sv
// Scoreboard bench for parser_grp_sched: the driver predicts strobe/done
// timing per vector, the monitor compares every cycle against a bank model.
module tb_parser_grp_sched;
  import parser_grp_sched_pkg::*;

  typedef logic [N_GROUPS*GROUP_W-1:0] vec_t;
  typedef struct {
    int                 cyc;
    logic [GROUP_W-1:0] data;
  } strobe_t;

  logic axis_clk = 1'b0;
  logic areset   = 1'b1;
  int   cyc      = 0;
  int   errors   = 0;
  int   checks   = 0;
  int   last_done = 0;

  strobe_t exp_q[$];
  int      exp_done_q[$];

  bit [1:0]           m_full = 2'b00;
  bit                 m_wr = 0, m_rd = 0, m_ovr = 0, m_busy = 0, m_en = 0;
  logic [GROUP_W-1:0] m_bram = '0;

  parser_grp_sched_if bus();

  parser_grp_sched dut (
    .axis_clk (axis_clk),
    .areset   (areset),
    .bus      (bus)
  );

  always #5 axis_clk = ~axis_clk;
  always @(posedge axis_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [GROUP_W-1:0] act, input logic [GROUP_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference timing: strobes on live groups GROUP_GAP apart, one cycle per
  // dead group, release after the walk, done one cycle after release.
  task automatic push_vec(input vec_t v, input int hs_cyc, output int done_cyc);
    int t;
    strobe_t e;
    logic [GROUP_W-1:0] g;
    t = hs_cyc + 1;
    for (int k = 0; k < N_GROUPS; k++) begin
      g = v[k*GROUP_W +: GROUP_W];
      if (g[31] || g[15]) begin
        e.cyc  = t;
        e.data = g;
        exp_q.push_back(e);
        t += GROUP_GAP;
      end else begin
        t += 1;
      end
    end
    done_cyc = t + 1;
    exp_done_q.push_back(done_cyc);
  endtask

  task automatic step(input bit v, input vec_t vec, input bit se, output bit hs);
    int d;
    bus.i_inst_valid = v;
    bus.i_inst_vec   = vec;
    bus.i_seg_end    = se;
    hs = v && bus.o_inst_ready;
    if (hs) begin
      push_vec(vec, cyc, d);
      last_done = d;
    end
    @(posedge axis_clk);
    #2;
    bus.i_inst_valid = 1'b0;
    bus.i_seg_end    = 1'b0;
  endtask

  task automatic idle(input int n, input bit rand_se);
    bit hs;
    for (int i = 0; i < n; i++) step(1'b0, '0, rand_se && ($urandom_range(0, 4) == 0), hs);
  endtask

  task automatic wait_cyc(input int c);
    bit hs;
    while (cyc < c) step(1'b0, '0, 1'b0, hs);
  endtask

  task automatic send_vec(input vec_t vec, input bit rand_se);
    bit hs;
    int n;
    hs = 0;
    n  = 0;
    while (!hs && n < 200) begin
      step(1'b1, vec, rand_se && ($urandom_range(0, 3) == 0), hs);
      n++;
    end
    chk("inst_handshake", hs, 1'b1);
  endtask

  task automatic do_reset(input int n);
    areset = 1'b1;
    exp_q.delete();
    exp_done_q.delete();
    repeat (n) begin
      @(posedge axis_clk);
      #2;
    end
    areset = 1'b0;
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    logic [GROUP_W-1:0] g;
    for (int k = 0; k < N_GROUPS; k++) begin
      g = $urandom;
      if ($urandom_range(0, 2) == 0) g = g & 32'h7FFF_7FFF;
      v[k*GROUP_W +: GROUP_W] = g;
    end
    return v;
  endfunction

  // Monitor: compare every output, then advance the bank model for the next edge.
  always @(negedge axis_clk) begin
    bit exp_ready, exp_sr, exp_v, exp_d;
    if (areset) begin
      chk("rst_inst_ready", bus.o_inst_ready, 1'b0);
      chk("rst_seg_ready", bus.o_seg_ready, 1'b0);
      chk("rst_wr_bank", bus.o_wr_bank, 1'b0);
      chk("rst_rd_bank", bus.o_rd_bank, 1'b0);
      chk("rst_bram", bus.o_parser_bram, '0);
      chk("rst_bram_valid", bus.o_parser_bram_valid, 1'b0);
      chk("rst_done", bus.o_done, 1'b0);
      chk("rst_overrun", bus.o_overrun, 1'b0);
      m_full = 2'b00; m_wr = 0; m_rd = 0; m_ovr = 0; m_busy = 0; m_en = 0; m_bram = '0;
    end else begin
      exp_ready = !m_busy && m_full[m_rd];
      exp_sr    = m_en && !m_full[m_wr];
      chk("inst_ready", bus.o_inst_ready, exp_ready);
      chk("seg_ready", bus.o_seg_ready, exp_sr);
      chk("wr_bank", bus.o_wr_bank, m_wr);
      chk("rd_bank", bus.o_rd_bank, m_rd);
      chk("overrun", bus.o_overrun, m_ovr);
      exp_v = (exp_q.size() != 0) && (exp_q[0].cyc == cyc);
      chk("bram_valid", bus.o_parser_bram_valid, exp_v);
      if (exp_v) begin
        m_bram = exp_q[0].data;
        void'(exp_q.pop_front());
      end
      chk("parser_bram", bus.o_parser_bram, m_bram);
      exp_d = (exp_done_q.size() != 0) && (exp_done_q[0] == cyc);
      chk("done", bus.o_done, exp_d);
      if (exp_d) void'(exp_done_q.pop_front());
      if (bus.i_seg_end) begin
        if (exp_sr) begin
          m_full[m_wr] = 1'b1;
          m_wr = !m_wr;
        end else begin
          m_ovr = 1'b1;
        end
      end
      if ((exp_done_q.size() != 0) && (exp_done_q[0] == cyc + 1)) begin
        m_full[m_rd] = 1'b0;
        m_rd   = !m_rd;
        m_busy = 1'b0;
      end
      if (bus.i_inst_valid && exp_ready) m_busy = 1'b1;
      m_en = 1'b1;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vec_all, vec_skip, vec_dead;
    bit   hs;
    int   fifth;
    bus.i_inst_valid = 1'b0;
    bus.i_inst_vec   = '0;
    bus.i_seg_end    = 1'b0;
    vec_all  = {N_GROUPS{32'h8081_8080}};
    vec_dead = '0;
    for (int k = 0; k < N_GROUPS; k++) begin
      vec_skip[k*GROUP_W +: GROUP_W] = $urandom & 32'h7FFF_7FFF;
    end
    vec_skip[0*GROUP_W +: GROUP_W]  = vec_skip[0*GROUP_W +: GROUP_W] | 32'h8000_0000;
    vec_skip[11*GROUP_W +: GROUP_W] = vec_skip[11*GROUP_W +: GROUP_W] | 32'h0000_8000;

    repeat (3) @(posedge axis_clk);
    #2;
    areset = 1'b0;

    // Valid with no full bank: no handshake.
    for (int i = 0; i < 4; i++) step(1'b1, vec_all, 1'b0, hs);

    // All groups live, paced GROUP_GAP apart.
    step(1'b0, '0, 1'b1, hs);
    send_vec(vec_all, 1'b0);
    wait_cyc(last_done + 2);

    // Only groups 0 and 11 live.
    step(1'b0, '0, 1'b1, hs);
    send_vec(vec_skip, 1'b0);
    wait_cyc(last_done + 2);

    // Fill both banks, then an extra segment end is an overrun.
    step(1'b0, '0, 1'b1, hs);
    step(1'b0, '0, 1'b1, hs);
    step(1'b0, '0, 1'b1, hs);
    idle(2, 1'b0);
    send_vec(vec_all, 1'b0);
    wait_cyc(last_done + 2);

    // All-dead vector; writer fills the other bank during its release cycle.
    send_vec(vec_dead, 1'b0);
    wait_cyc(last_done - 1);
    step(1'b0, '0, 1'b1, hs);
    step(1'b1, vec_all, 1'b0, hs);
    chk("accept_after_release", hs, 1'b1);
    wait_cyc(last_done + 2);

    // Reset in the cycle of the fifth strobe.
    step(1'b0, '0, 1'b1, hs);
    send_vec(vec_all, 1'b0);
    fifth = (exp_q.size() > 4) ? exp_q[4].cyc : cyc;
    wait_cyc(fifth);
    do_reset(3);
    idle(60, 1'b0);

    // Random traffic.
    for (int n = 0; n < 25; n++) begin
      idle($urandom_range(0, 6), 1'b1);
      send_vec(rand_vec(), 1'b1);
    end
    wait_cyc(last_done + 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
